// File: rtl/fetch_queue_unit.sv
// -----------------------------------------------------------------------------
// fetch_queue_unit
//   Instruction-fetch front end. Holds the fetch PC and requests whole lines
//   from the instruction cache. It keeps the most recent line in a one-line
//   buffer and takes one instruction per cycle from it. Each instruction is
//   queued with its PC in a small FIFO that decode drains through a
//   valid/ready handshake. A branch redirect flushes the queue and the line
//   buffer. A response that was still in flight on the squashed path is
//   dropped.
//
// Ports
//   clock              : system clock
//   reset              : synchronous, active-low reset
//   boot_addr          : PC loaded while reset is low
//   take_branch        : one-cycle redirect strobe, wins over all other actions
//   branch_pc          : redirect target (instruction aligned)
//   stall_fetch        : blocks new icache requests and line-buffer pushes
//   icache_req_valid   : line request valid (combinational from state and pc)
//   icache_req_addr    : line-aligned request address
//   icache_req_ready   : icache accepts the request
//   icache_rsp_valid   : one-cycle line response strobe
//   icache_rsp_data    : line data, instruction i at [i*INSTR_WIDTH +: INSTR_WIDTH]
//   decode_instr_valid : queue head valid
//   decode_instr_data  : queue head instruction (zero when not valid)
//   decode_instr_pc    : queue head PC (zero when not valid)
//   decode_ready       : decode pops the head when valid & ready
// -----------------------------------------------------------------------------
module fetch_queue_unit #(
  parameter int PC_WIDTH    = 32,
  parameter int INSTR_WIDTH = 32,
  parameter int LINE_WIDTH  = 128,
  parameter int FQ_DEPTH    = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [PC_WIDTH-1:0]    boot_addr,
  input  logic                   take_branch,
  input  logic [PC_WIDTH-1:0]    branch_pc,
  input  logic                   stall_fetch,
  output logic                   icache_req_valid,
  output logic [PC_WIDTH-1:0]    icache_req_addr,
  input  logic                   icache_req_ready,
  input  logic                   icache_rsp_valid,
  input  logic [LINE_WIDTH-1:0]  icache_rsp_data,
  output logic                   decode_instr_valid,
  output logic [INSTR_WIDTH-1:0] decode_instr_data,
  output logic [PC_WIDTH-1:0]    decode_instr_pc,
  input  logic                   decode_ready
);

  localparam int INSTR_BYTES = INSTR_WIDTH / 8;
  localparam int IPL         = LINE_WIDTH / INSTR_WIDTH;
  localparam int OFF         = $clog2(LINE_WIDTH / 8);
  localparam int IOFF        = $clog2(INSTR_BYTES);
  localparam int IDX_W       = $clog2(IPL);
  localparam int TAG_W       = PC_WIDTH - OFF;
  localparam int PTR_W       = $clog2(FQ_DEPTH);
  localparam int CNT_W       = PTR_W + 1;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  // Select instruction slot idx out of a cache line.
  function automatic logic [INSTR_WIDTH-1:0] pick_instr(
    input logic [LINE_WIDTH-1:0] line,
    input logic [IDX_W-1:0]      idx
  );
    pick_instr = line[int'(idx) * INSTR_WIDTH +: INSTR_WIDTH];
  endfunction

  // Control state
  state_t              r_state;
  logic [PC_WIDTH-1:0] r_pc;
  logic [CNT_W-1:0]    r_count;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [PTR_W-1:0]    r_wr_ptr;
  logic                r_lb_valid;

  // Data storage (no reset: qualified by r_lb_valid / r_count)
  logic [LINE_WIDTH-1:0]  r_lb_line;
  logic [TAG_W-1:0]       r_lb_tag;
  logic [INSTR_WIDTH-1:0] r_fq_data [FQ_DEPTH];
  logic [PC_WIDTH-1:0]    r_fq_pc   [FQ_DEPTH];

  logic [TAG_W-1:0]       w_tag;
  logic [IDX_W-1:0]       w_index;
  logic                   w_hit;
  logic                   w_space;
  logic                   w_req_valid;
  logic                   w_req_fire;
  logic                   w_lb_push;
  logic                   w_rsp_push;
  logic                   w_push;
  logic                   w_pop;
  logic [INSTR_WIDTH-1:0] w_push_data;

  assign w_tag   = r_pc[PC_WIDTH-1:OFF];
  assign w_index = r_pc[OFF-1:IOFF];
  assign w_hit   = r_lb_valid && (r_lb_tag == w_tag);
  // Space is judged on the registered count only: a pop in the same cycle
  // does not open a slot for a push.
  assign w_space = (r_count < CNT_W'(FQ_DEPTH));

  // The request is gated by reset so nothing is offered while held in reset.
  assign w_req_valid = reset && (r_state == S_REQ) && !w_hit && !stall_fetch && w_space;
  assign w_req_fire  = w_req_valid && icache_req_ready;

  assign w_lb_push  = (r_state == S_REQ) && w_hit && !stall_fetch && w_space;
  // The slot for a response was reserved when the request was issued, so
  // neither space nor stall_fetch are re-checked here.
  assign w_rsp_push = (r_state == S_WAIT) && icache_rsp_valid;
  assign w_push     = !take_branch && (w_lb_push || w_rsp_push);
  assign w_pop      = (r_count != '0) && decode_ready && !take_branch;

  assign w_push_data = w_rsp_push ? pick_instr(icache_rsp_data, w_index)
                                  : pick_instr(r_lb_line, w_index);

  assign icache_req_valid = w_req_valid;
  assign icache_req_addr  = {w_tag, {OFF{1'b0}}};

  assign decode_instr_valid = (r_count != '0);
  assign decode_instr_data  = decode_instr_valid ? r_fq_data[r_rd_ptr] : '0;
  assign decode_instr_pc    = decode_instr_valid ? r_fq_pc[r_rd_ptr]   : '0;

  // FSM, PC and queue bookkeeping
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state    <= S_REQ;
      r_pc       <= boot_addr;
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_lb_valid <= 1'b0;
    end else if (take_branch) begin
      r_pc       <= branch_pc;
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_lb_valid <= 1'b0;
      case (r_state)
        // A request accepted this very cycle belongs to the old path.
        S_REQ:   r_state <= w_req_fire ? S_DRAIN : S_REQ;
        // A response arriving with the redirect is simply dropped.
        S_WAIT:  r_state <= icache_rsp_valid ? S_REQ : S_DRAIN;
        // The awaited stale response still retires the drain if it lands now.
        S_DRAIN: r_state <= icache_rsp_valid ? S_REQ : S_DRAIN;
        default: r_state <= S_REQ;
      endcase
    end else begin
      if (w_push) begin
        r_pc     <= r_pc + PC_WIDTH'(INSTR_BYTES);
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (w_rsp_push) begin
        r_lb_valid <= 1'b1;
      end
      case (r_state)
        S_REQ:   if (w_req_fire) r_state <= S_WAIT;
        S_WAIT:  if (icache_rsp_valid) r_state <= S_REQ;
        S_DRAIN: if (icache_rsp_valid) r_state <= S_REQ;
        default: r_state <= S_REQ;
      endcase
    end
  end

  // Line buffer and queue storage
  always_ff @(posedge clock) begin
    if (w_rsp_push && !take_branch) begin
      r_lb_line <= icache_rsp_data;
      r_lb_tag  <= w_tag;
    end
    if (reset && w_push) begin
      r_fq_data[r_wr_ptr] <= w_push_data;
      r_fq_pc[r_wr_ptr]   <= r_pc;
    end
  end

endmodule

// File: tb/tb_fetch_queue_unit.sv
module tb_fetch_queue_unit;

  logic         clock = 1'b0;
  logic         reset;
  logic [31:0]  boot_addr;
  logic         take_branch;
  logic [31:0]  branch_pc;
  logic         stall_fetch;
  logic         icache_req_valid;
  logic [31:0]  icache_req_addr;
  logic         icache_req_ready;
  logic         icache_rsp_valid;
  logic [127:0] icache_rsp_data;
  logic         decode_instr_valid;
  logic [31:0]  decode_instr_data;
  logic [31:0]  decode_instr_pc;
  logic         decode_ready;

  int total = 0;
  int bad   = 0;

  fetch_queue_unit #(
    .PC_WIDTH(32), .INSTR_WIDTH(32), .LINE_WIDTH(128), .FQ_DEPTH(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .boot_addr(boot_addr),
    .take_branch(take_branch),
    .branch_pc(branch_pc),
    .stall_fetch(stall_fetch),
    .icache_req_valid(icache_req_valid),
    .icache_req_addr(icache_req_addr),
    .icache_req_ready(icache_req_ready),
    .icache_rsp_valid(icache_rsp_valid),
    .icache_rsp_data(icache_rsp_data),
    .decode_instr_valid(decode_instr_valid),
    .decode_instr_data(decode_instr_data),
    .decode_instr_pc(decode_instr_pc),
    .decode_ready(decode_ready)
  );

  always #5 clock = ~clock;

  // Memory image: every address holds a distinct instruction word.
  function automatic logic [31:0] instr_at(input logic [31:0] pc);
    return (pc * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // Line holding addr: slot i is the word at line base + 4*i.
  function automatic logic [127:0] line_at(input logic [31:0] addr);
    logic [127:0] l;
    logic [31:0]  base;
    base = {addr[31:4], 4'h0};
    for (int i = 0; i < 4; i++) l[i*32 +: 32] = instr_at(base + 32'(i * 4));
    return l;
  endfunction

  task automatic idle_inputs();
    take_branch      = 1'b0;
    branch_pc        = '0;
    stall_fetch      = 1'b0;
    icache_req_ready = 1'b0;
    icache_rsp_valid = 1'b0;
    icache_rsp_data  = '0;
    decode_ready     = 1'b0;
  endtask

  // Ends on the negedge where reset has just been released.
  task automatic do_reset(input logic [31:0] boot);
    @(negedge clock);
    idle_inputs();
    reset     = 1'b0;
    boot_addr = boot;
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  // Called at a negedge while a request is showing: accept it, answer one
  // cycle later, and return on the negedge after the response edge.
  task automatic serve_line(input logic [31:0] addr);
    icache_req_ready = 1'b1;
    @(negedge clock);
    icache_req_ready = 1'b0;
    @(negedge clock);
    icache_rsp_valid = 1'b1;
    icache_rsp_data  = line_at(addr);
    @(negedge clock);
    icache_rsp_valid = 1'b0;
    icache_rsp_data  = '0;
  endtask

  task automatic test_reset();
    @(negedge clock);
    idle_inputs();
    reset = 1'b0; boot_addr = 32'h1000;
    decode_ready = 1'b1; icache_req_ready = 1'b1;
    repeat (2) @(negedge clock);
    #1;
    total++; if (icache_req_valid !== 1'b0) begin bad++; $display("FAIL rst_req_valid got=%0b want=0", icache_req_valid); end
    total++; if (decode_instr_valid !== 1'b0) begin bad++; $display("FAIL rst_dec_valid got=%0b want=0", decode_instr_valid); end
    total++; if (decode_instr_data !== 32'h0) begin bad++; $display("FAIL rst_dec_data got=%h want=0", decode_instr_data); end
    total++; if (decode_instr_pc !== 32'h0) begin bad++; $display("FAIL rst_dec_pc got=%h want=0", decode_instr_pc); end
    @(negedge clock);
    reset = 1'b1; icache_req_ready = 1'b0;
    #1;
    total++; if (icache_req_valid !== 1'b1) begin bad++; $display("FAIL rst_first_req got=%0b want=1", icache_req_valid); end
    total++; if (icache_req_addr !== 32'h1000) begin bad++; $display("FAIL rst_first_addr got=%h want=00001000", icache_req_addr); end
  endtask

  task automatic test_line_fetch();
    do_reset(32'h1000);
    decode_ready = 1'b1;
    #1;
    total++; if (icache_req_valid !== 1'b1 || icache_req_addr !== 32'h1000) begin bad++; $display("FAIL t1_req got=%0b/%h want=1/00001000", icache_req_valid, icache_req_addr); end
    icache_req_ready = 1'b1;
    @(negedge clock);
    icache_req_ready = 1'b0;
    #1;
    total++; if (icache_req_valid !== 1'b0) begin bad++; $display("FAIL t1_wait_req got=%0b want=0", icache_req_valid); end
    @(negedge clock);
    icache_rsp_valid = 1'b1; icache_rsp_data = line_at(32'h1000);
    @(negedge clock);
    icache_rsp_valid = 1'b0; icache_rsp_data = '0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clock);
      #1;
      total++; if (decode_instr_valid !== 1'b1 || decode_instr_pc !== 32'h1000 + 32'(4 * i)) begin bad++; $display("FAIL t1_pc[%0d] got=%0b/%h want=1/%h", i, decode_instr_valid, decode_instr_pc, 32'h1000 + 32'(4 * i)); end
      total++; if (decode_instr_data !== instr_at(32'h1000 + 32'(4 * i))) begin bad++; $display("FAIL t1_data[%0d] got=%h want=%h", i, decode_instr_data, instr_at(32'h1000 + 32'(4 * i))); end
      if (i < 3) begin
        total++; if (icache_req_valid !== 1'b0) begin bad++; $display("FAIL t1_lb_noreq[%0d] got=%0b want=0", i, icache_req_valid); end
      end else begin
        total++; if (icache_req_valid !== 1'b1 || icache_req_addr !== 32'h1010) begin bad++; $display("FAIL t1_next_req got=%0b/%h want=1/00001010", icache_req_valid, icache_req_addr); end
      end
    end
  endtask

  task automatic test_queue_full();
    do_reset(32'h1000);
    serve_line(32'h1000);
    repeat (4) @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clock);
      #1;
      total++; if (icache_req_valid !== 1'b0) begin bad++; $display("FAIL t2_full_noreq[%0d] got=%0b want=0", i, icache_req_valid); end
      total++; if (decode_instr_valid !== 1'b1 || decode_instr_pc !== 32'h1000) begin bad++; $display("FAIL t2_full_head[%0d] got=%0b/%h want=1/00001000", i, decode_instr_valid, decode_instr_pc); end
    end
    @(negedge clock);
    decode_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clock);
      #1;
      total++; if (decode_instr_valid !== 1'b1 || decode_instr_pc !== 32'h1000 + 32'(4 * i)) begin bad++; $display("FAIL t2_pop[%0d] got=%0b/%h want=1/%h", i, decode_instr_valid, decode_instr_pc, 32'h1000 + 32'(4 * i)); end
      if (i == 0) begin
        total++; if (icache_req_valid !== 1'b0) begin bad++; $display("FAIL t2_nobypass got=%0b want=0", icache_req_valid); end
      end else begin
        total++; if (icache_req_valid !== 1'b1 || icache_req_addr !== 32'h1010) begin bad++; $display("FAIL t2_resume[%0d] got=%0b/%h want=1/00001010", i, icache_req_valid, icache_req_addr); end
      end
    end
    @(negedge clock);
    #1;
    total++; if (decode_instr_valid !== 1'b0) begin bad++; $display("FAIL t2_empty got=%0b want=0", decode_instr_valid); end
  endtask

  task automatic test_branch_wait();
    do_reset(32'h1000);
    decode_ready = 1'b1;
    serve_line(32'h1000);
    repeat (3) @(negedge clock);
    #1;
    total++; if (icache_req_valid !== 1'b1 || icache_req_addr !== 32'h1010) begin bad++; $display("FAIL t3_req1010 got=%0b/%h want=1/00001010", icache_req_valid, icache_req_addr); end
    icache_req_ready = 1'b1;
    @(negedge clock);
    icache_req_ready = 1'b0; take_branch = 1'b1; branch_pc = 32'h2008;
    @(negedge clock);
    take_branch = 1'b0;
    icache_rsp_valid = 1'b1; icache_rsp_data = line_at(32'h1010);
    #1;
    total++; if (icache_req_valid !== 1'b0) begin bad++; $display("FAIL t3_drain_noreq got=%0b want=0", icache_req_valid); end
    @(negedge clock);
    icache_rsp_valid = 1'b0; icache_rsp_data = '0;
    #1;
    total++; if (decode_instr_valid !== 1'b0) begin bad++; $display("FAIL t3_stale_drop got=%0b want=0", decode_instr_valid); end
    total++; if (icache_req_valid !== 1'b1 || icache_req_addr !== 32'h2000) begin bad++; $display("FAIL t3_req2000 got=%0b/%h want=1/00002000", icache_req_valid, icache_req_addr); end
    serve_line(32'h2000);
    #1;
    total++; if (decode_instr_valid !== 1'b1 || decode_instr_pc !== 32'h2008 || decode_instr_data !== instr_at(32'h2008)) begin bad++; $display("FAIL t3_first got=%0b/%h/%h want=1/00002008/%h", decode_instr_valid, decode_instr_pc, decode_instr_data, instr_at(32'h2008)); end
    @(negedge clock);
    #1;
    total++; if (decode_instr_valid !== 1'b1 || decode_instr_pc !== 32'h200C || decode_instr_data !== instr_at(32'h200C)) begin bad++; $display("FAIL t3_second got=%0b/%h/%h want=1/0000200c/%h", decode_instr_valid, decode_instr_pc, decode_instr_data, instr_at(32'h200C)); end
    total++; if (icache_req_valid !== 1'b1 || icache_req_addr !== 32'h2010) begin bad++; $display("FAIL t3_req2010 got=%0b/%h want=1/00002010", icache_req_valid, icache_req_addr); end
  endtask

  task automatic test_branch_with_rsp();
    do_reset(32'h1000);
    serve_line(32'h1000);
    repeat (3) @(negedge clock);
    #1;
    total++; if (icache_req_valid !== 1'b0) begin bad++; $display("FAIL t4_full_noreq got=%0b want=0", icache_req_valid); end
    decode_ready = 1'b1;
    @(negedge clock);
    decode_ready = 1'b0;
    #1;
    total++; if (icache_req_valid !== 1'b1 || icache_req_addr !== 32'h1010) begin bad++; $display("FAIL t4_req1010 got=%0b/%h want=1/00001010", icache_req_valid, icache_req_addr); end
    icache_req_ready = 1'b1;
    @(negedge clock);
    icache_req_ready = 1'b0;
    icache_rsp_valid = 1'b1; icache_rsp_data = line_at(32'h1010);
    take_branch = 1'b1; branch_pc = 32'h3004; decode_ready = 1'b1;
    #1;
    total++; if (decode_instr_valid !== 1'b1 || decode_instr_pc !== 32'h1004) begin bad++; $display("FAIL t4_prebranch_head got=%0b/%h want=1/00001004", decode_instr_valid, decode_instr_pc); end
    @(negedge clock);
    take_branch = 1'b0; icache_rsp_valid = 1'b0; icache_rsp_data = '0; decode_ready = 1'b0;
    #1;
    total++; if (decode_instr_valid !== 1'b0) begin bad++; $display("FAIL t4_flushed got=%0b want=0", decode_instr_valid); end
    total++; if (icache_req_valid !== 1'b1 || icache_req_addr !== 32'h3000) begin bad++; $display("FAIL t4_req3000 got=%0b/%h want=1/00003000", icache_req_valid, icache_req_addr); end
    serve_line(32'h3000);
    #1;
    total++; if (decode_instr_valid !== 1'b1 || decode_instr_pc !== 32'h3004 || decode_instr_data !== instr_at(32'h3004)) begin bad++; $display("FAIL t4_first got=%0b/%h/%h want=1/00003004/%h", decode_instr_valid, decode_instr_pc, decode_instr_data, instr_at(32'h3004)); end
  endtask

  task automatic test_stall();
    do_reset(32'h1000);
    stall_fetch = 1'b1;
    for (int i = 0; i < 2; i++) begin
      if (i > 0) @(negedge clock);
      #1;
      total++; if (icache_req_valid !== 1'b0) begin bad++; $display("FAIL t5_stall_noreq[%0d] got=%0b want=0", i, icache_req_valid); end
    end
    @(negedge clock);
    stall_fetch = 1'b0;
    #1;
    total++; if (icache_req_valid !== 1'b1 || icache_req_addr !== 32'h1000) begin bad++; $display("FAIL t5_req got=%0b/%h want=1/00001000", icache_req_valid, icache_req_addr); end
    icache_req_ready = 1'b1;
    @(negedge clock);
    icache_req_ready = 1'b0; stall_fetch = 1'b1;
    @(negedge clock);
    icache_rsp_valid = 1'b1; icache_rsp_data = line_at(32'h1000);
    @(negedge clock);
    icache_rsp_valid = 1'b0; icache_rsp_data = '0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clock);
      #1;
      total++; if (decode_instr_valid !== 1'b1 || decode_instr_pc !== 32'h1000) begin bad++; $display("FAIL t5_rsp_pushed[%0d] got=%0b/%h want=1/00001000", i, decode_instr_valid, decode_instr_pc); end
      total++; if (icache_req_valid !== 1'b0) begin bad++; $display("FAIL t5_held_noreq[%0d] got=%0b want=0", i, icache_req_valid); end
    end
    decode_ready = 1'b1;
    @(negedge clock);
    #1;
    total++; if (decode_instr_valid !== 1'b0) begin bad++; $display("FAIL t5_single_push got=%0b want=0", decode_instr_valid); end
    stall_fetch = 1'b0;
    @(negedge clock);
    #1;
    total++; if (decode_instr_valid !== 1'b1 || decode_instr_pc !== 32'h1004 || decode_instr_data !== instr_at(32'h1004)) begin bad++; $display("FAIL t5_resume got=%0b/%h/%h want=1/00001004/%h", decode_instr_valid, decode_instr_pc, decode_instr_data, instr_at(32'h1004)); end
  endtask

  task automatic test_reset_mid();
    do_reset(32'h1000);
    decode_ready = 1'b1;
    #1;
    icache_req_ready = 1'b1;
    @(negedge clock);
    icache_req_ready = 1'b0; reset = 1'b0; boot_addr = 32'h4010;
    @(negedge clock);
    #1;
    total++; if (icache_req_valid !== 1'b0 || decode_instr_valid !== 1'b0) begin bad++; $display("FAIL t6_in_reset got=%0b/%0b want=0/0", icache_req_valid, decode_instr_valid); end
    @(negedge clock);
    reset = 1'b1;
    #1;
    total++; if (icache_req_valid !== 1'b1 || icache_req_addr !== 32'h4010) begin bad++; $display("FAIL t6_boot_req got=%0b/%h want=1/00004010", icache_req_valid, icache_req_addr); end
    icache_rsp_valid = 1'b1; icache_rsp_data = line_at(32'h1000);
    @(negedge clock);
    icache_rsp_valid = 1'b0; icache_rsp_data = '0;
    #1;
    total++; if (decode_instr_valid !== 1'b0) begin bad++; $display("FAIL t6_late_rsp got=%0b want=0", decode_instr_valid); end
    total++; if (icache_req_valid !== 1'b1 || icache_req_addr !== 32'h4010) begin bad++; $display("FAIL t6_req_held got=%0b/%h want=1/00004010", icache_req_valid, icache_req_addr); end
    serve_line(32'h4010);
    #1;
    total++; if (decode_instr_valid !== 1'b1 || decode_instr_pc !== 32'h4010 || decode_instr_data !== instr_at(32'h4010)) begin bad++; $display("FAIL t6_first got=%0b/%h/%h want=1/00004010/%h", decode_instr_valid, decode_instr_pc, decode_instr_data, instr_at(32'h4010)); end
  endtask

  // Random traffic against a program-order model: decode must see the
  // instruction stream starting at the boot/branch target, one word apart,
  // with each word equal to the memory image at that PC.
  task automatic test_random();
    logic [31:0] exp_pc;
    logic [31:0] out_addr;
    logic [31:0] boot;
    bit          outst;
    int          delay;
    int          pops;
    boot = $urandom & 32'hFFFF_FFFC;
    do_reset(boot);
    exp_pc = boot; outst = 1'b0; delay = 0; pops = 0; out_addr = '0;
    for (int c = 0; c < 3000; c++) begin
      if (c > 0) @(negedge clock);
      decode_ready = ($urandom_range(3) != 0);
      stall_fetch  = ($urandom_range(9) == 0);
      take_branch  = ($urandom_range(39) == 0);
      branch_pc    = $urandom & 32'hFFFF_FFFC;
      icache_rsp_valid = 1'b0; icache_rsp_data = '0;
      if (outst) begin
        if (delay == 0) begin
          icache_rsp_valid = 1'b1;
          icache_rsp_data  = line_at(out_addr);
          outst = 1'b0;
        end else begin
          delay--;
        end
      end
      #1;
      if (decode_instr_valid && decode_ready && !take_branch) begin
        total++; if (decode_instr_pc !== exp_pc) begin bad++; $display("FAIL rnd_pc c=%0d got=%h want=%h", c, decode_instr_pc, exp_pc); end
        total++; if (decode_instr_data !== instr_at(exp_pc)) begin bad++; $display("FAIL rnd_data c=%0d got=%h want=%h", c, decode_instr_data, instr_at(exp_pc)); end
        exp_pc = exp_pc + 32'd4;
        pops++;
      end
      if (take_branch) exp_pc = branch_pc;
      icache_req_ready = ($urandom_range(2) != 0);
      if (icache_req_valid && icache_req_ready) begin
        total++; if (outst || icache_rsp_valid) begin bad++; $display("FAIL rnd_one_outstanding c=%0d got=2 want=1", c); end
        total++; if (icache_req_addr[3:0] !== 4'h0) begin bad++; $display("FAIL rnd_req_align c=%0d got=%h want=line-aligned", c, icache_req_addr); end
        outst    = 1'b1;
        out_addr = icache_req_addr;
        delay    = $urandom_range(3);
      end
    end
    @(negedge clock);
    idle_inputs();
    total++; if (pops < 200) begin bad++; $display("FAIL rnd_progress got=%0d want>=200", pops); end
  endtask

  initial begin
    reset = 1'b0;
    boot_addr = '0;
    idle_inputs();
    test_reset();
    test_line_fetch();
    test_queue_full();
    test_branch_wait();
    test_branch_with_rsp();
    test_stall();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
